// File: rtl/median_window_ctrl_pkg.sv
// rtl/median_window_ctrl_pkg.sv - shared constants, state encoding and window helpers
package median_window_ctrl_pkg;

  localparam int DATA_LENGTH = 32;
  localparam int WMAX        = 16;
  localparam int LOG_WMAX    = 4;

  localparam logic [LOG_WMAX:0] WMAX_W = (LOG_WMAX+1)'(WMAX);
  localparam logic [LOG_WMAX:0] WMIN_W = (LOG_WMAX+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_FILL      = 3'd2,
    ST_RUN       = 3'd3,
    ST_CLEAR_OUT = 3'd4
  } state_e;

  // A zero window would never fill, and the history buffer cannot exceed WMAX.
  function automatic logic [LOG_WMAX:0] clamp_w(input logic [LOG_WMAX:0] w);
    if (w == '0) begin
      return WMIN_W;
    end else if (w > WMAX_W) begin
      return WMAX_W;
    end
    return w;
  endfunction

  function automatic logic [LOG_WMAX-1:0] med_tap(input logic [LOG_WMAX:0] w);
    return LOG_WMAX'((w - WMIN_W) >> 1);
  endfunction

endpackage

// File: rtl/median_window_ctrl_history_buf.sv
// rtl/median_window_ctrl_history_buf.sv - window_history_buf: W-deep sample history with read-before-write port
module window_history_buf
  import median_window_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [LOG_WMAX:0]      w_len_i,
  input  logic [DATA_LENGTH-1:0] wr_data_i,
  output logic [DATA_LENGTH-1:0] rd_data_o
);

  logic [DATA_LENGTH-1:0] mem_q [WMAX];
  logic [LOG_WMAX-1:0]    wp_q;
  logic [DATA_LENGTH-1:0] rd_q;
  logic                   wp_last;

  // Wrap at the configured window length so the entry read back is exactly W samples old.
  assign wp_last   = ({1'b0, wp_q} == (w_len_i - WMIN_W));
  assign rd_data_o = rd_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < WMAX; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wp_q <= '0;
    end else if (wr_en_i) begin
      rd_q        <= mem_q[wp_q];
      mem_q[wp_q] <= wr_data_i;
      wp_q        <= wp_last ? '0 : wp_q + 1'b1;
    end
  end

endmodule

// File: rtl/median_window_ctrl.sv
// rtl/median_window_ctrl.sv - sequencer feeding the systolic median filter array
module median_window_ctrl
  import median_window_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LOG_WMAX:0]      cfg_w,
  input  logic                   in_valid,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic [DATA_LENGTH-1:0] arr_x,
  output logic [DATA_LENGTH-1:0] arr_old,
  output logic                   arr_old_vld,
  output logic                   arr_ce,
  output logic                   arr_clear,
  output logic                   med_valid,
  input  logic                   med_ready,
  output logic [LOG_WMAX-1:0]    med_sel,
  output logic                   busy
);

  state_e                 state_q;
  logic [LOG_WMAX:0]      w_q;
  logic [LOG_WMAX:0]      fill_cnt_q;
  logic [LOG_WMAX:0]      fill_cnt_d;
  logic [LOG_WMAX-1:0]    med_sel_q;
  logic [DATA_LENGTH-1:0] arr_x_q;
  logic                   arr_old_vld_q;
  logic                   arr_ce_q;
  logic                   arr_clear_q;
  logic                   med_valid_q;
  logic                   pend_q;
  logic                   busy_q;
  logic                   accept;
  logic                   streaming;
  logic [LOG_WMAX:0]      w_clamped;
  logic [DATA_LENGTH-1:0] hist_rd;

  assign streaming  = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign in_ready   = streaming && !stop && (!med_valid_q || med_ready);
  assign accept     = in_valid && in_ready;
  assign fill_cnt_d = fill_cnt_q + WMIN_W;
  assign w_clamped  = clamp_w(cfg_w);

  window_history_buf u_hist (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (state_q == ST_CLEAR),
    .wr_en_i   (accept),
    .w_len_i   (w_q),
    .wr_data_i (in_data),
    .rd_data_o (hist_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      w_q           <= '0;
      fill_cnt_q    <= '0;
      med_sel_q     <= '0;
      arr_x_q       <= '0;
      arr_old_vld_q <= 1'b0;
      arr_ce_q      <= 1'b0;
      arr_clear_q   <= 1'b0;
      med_valid_q   <= 1'b0;
      pend_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      arr_ce_q      <= accept;
      arr_clear_q   <= 1'b0;
      arr_old_vld_q <= accept && (state_q == ST_RUN);
      if (accept) begin
        arr_x_q <= in_data;
      end
      // The array sees the sample one cycle after accept, so its median lands one cycle after that.
      pend_q      <= accept && ((state_q == ST_RUN) || (fill_cnt_d == w_q));
      med_valid_q <= pend_q || (med_valid_q && !med_ready);

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            w_q         <= w_clamped;
            med_sel_q   <= med_tap(w_clamped);
            state_q     <= ST_CLEAR;
            arr_clear_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          fill_cnt_q <= '0;
          state_q    <= ST_FILL;
        end
        ST_FILL, ST_RUN: begin
          if (stop) begin
            state_q     <= ST_CLEAR_OUT;
            arr_clear_q <= 1'b1;
            pend_q      <= 1'b0;
            med_valid_q <= 1'b0;
          end else if (accept && (state_q == ST_FILL)) begin
            fill_cnt_q <= fill_cnt_d;
            if (fill_cnt_d == w_q) begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_CLEAR_OUT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arr_x       = arr_x_q;
  assign arr_old     = hist_rd;
  assign arr_old_vld = arr_old_vld_q;
  assign arr_ce      = arr_ce_q;
  assign arr_clear   = arr_clear_q;
  assign med_valid   = med_valid_q;
  assign med_sel     = med_sel_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// tb/tb_median_window_ctrl.sv - directed self-checking bench for median_window_ctrl
module tb_median_window_ctrl;
  import median_window_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   stop;
  logic [LOG_WMAX:0]      cfg_w;
  logic                   in_valid;
  logic [DATA_LENGTH-1:0] in_data;
  logic                   in_ready;
  logic [DATA_LENGTH-1:0] arr_x;
  logic [DATA_LENGTH-1:0] arr_old;
  logic                   arr_old_vld;
  logic                   arr_ce;
  logic                   arr_clear;
  logic                   med_valid;
  logic                   med_ready;
  logic [LOG_WMAX-1:0]    med_sel;
  logic                   busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [LOG_WMAX:0] cfg;
    int                wr;
    int                sel;
  } cfg_vec_t;

  cfg_vec_t vecs [8];

  always #5 clk = ~clk;

  median_window_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .cfg_w       (cfg_w),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .arr_x       (arr_x),
    .arr_old     (arr_old),
    .arr_old_vld (arr_old_vld),
    .arr_ce      (arr_ce),
    .arr_clear   (arr_clear),
    .med_valid   (med_valid),
    .med_ready   (med_ready),
    .med_sel     (med_sel),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LOG_WMAX:0] w);
    cfg_w = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_w = '0;
  endtask

  task automatic send(input logic [31:0] v, output logic acc);
    in_valid = 1'b1;
    in_data  = v;
    #1;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arr_x"}, arr_x, 0);
    chk({tag, "_arr_old"}, arr_old, 0);
    chk({tag, "_old_vld"}, 32'(arr_old_vld), 0);
    chk({tag, "_arr_ce"}, 32'(arr_ce), 0);
    chk({tag, "_arr_clear"}, 32'(arr_clear), 0);
    chk({tag, "_med_valid"}, 32'(med_valid), 0);
    chk({tag, "_med_sel"}, 32'(med_sel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   clr_cnt;

    vecs[0] = '{cfg: 5'd0,  wr: 1,  sel: 0};
    vecs[1] = '{cfg: 5'd31, wr: 16, sel: 7};
    vecs[2] = '{cfg: 5'd5,  wr: 5,  sel: 2};
    vecs[3] = '{cfg: 5'd3,  wr: 3,  sel: 1};
    vecs[4] = '{cfg: 5'd4,  wr: 4,  sel: 1};
    vecs[5] = '{cfg: 5'd16, wr: 16, sel: 7};
    vecs[6] = '{cfg: 5'd2,  wr: 2,  sel: 0};
    vecs[7] = '{cfg: 5'd17, wr: 16, sel: 7};

    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_w = '0;
    in_valid = 1'b0; in_data = '0; med_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_idle("rst");

    // Window sizes, clamps, fill length, wrap and median timing.
    for (int i = 0; i < 8; i++) begin
      int base;
      base = (i + 1) * 100;
      do_start(vecs[i].cfg);
      chk("tbl_clear_pulse", 32'(arr_clear), 1);
      chk("tbl_med_sel", 32'(med_sel), 32'(vecs[i].sel));
      tick();
      chk("tbl_clear_done", 32'(arr_clear), 0);
      for (int k = 1; k <= vecs[i].wr + 2; k++) begin
        send(32'(base + k), acc);
        chk("tbl_accept", 32'(acc), 1);
        chk("tbl_arr_x", arr_x, 32'(base + k));
        chk("tbl_old_vld", 32'(arr_old_vld), 32'(k > vecs[i].wr));
        if (k > vecs[i].wr) chk("tbl_arr_old", arr_old, 32'(base + k - vecs[i].wr));
        if (k == vecs[i].wr) chk("tbl_med_early", 32'(med_valid), 0);
        if (k == vecs[i].wr + 1) chk("tbl_med_rise", 32'(med_valid), 1);
      end
      do_stop();
      chk("tbl_idle", 32'(busy), 0);
    end

    // W=5 stream 10..60, plus a start pulse mid-run that must be ignored.
    do_start(5'd5);
    tick();
    for (int k = 1; k <= 6; k++) begin
      send(32'(k * 10), acc);
      chk("w5_old_vld", 32'(arr_old_vld), 32'(k == 6));
      if (k == 5) chk("w5_med_n1", 32'(med_valid), 0);
      if (k == 6) begin
        chk("w5_med_n2", 32'(med_valid), 1);
        chk("w5_arr_old", arr_old, 10);
      end
    end
    chk("w5_med_sel", 32'(med_sel), 2);
    do_start(5'd3);
    chk("w5_start_ignored_sel", 32'(med_sel), 2);
    chk("w5_start_ignored_clr", 32'(arr_clear), 0);
    chk("w5_start_ignored_busy", 32'(busy), 1);
    do_stop();

    // W=3 wraps at 3, not WMAX.
    do_start(5'd3);
    tick();
    for (int k = 1; k <= 8; k++) begin
      send(32'(k), acc);
      if (k >= 4) begin
        chk("w3_old_vld", 32'(arr_old_vld), 1);
        chk("w3_arr_old", arr_old, 32'(k - 3));
      end
    end
    do_stop();

    // W=4 backpressure: array holds while the median is not consumed.
    med_ready = 1'b0;
    do_start(5'd4);
    tick();
    for (int k = 1; k <= 5; k++) begin
      send(32'(k), acc);
      chk("bp_fill_accept", 32'(acc), 1);
    end
    in_valid = 1'b1;
    in_data  = 32'd6;
    #1;
    chk("bp_blocked_ready", 32'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_ce", 32'(arr_ce), 0);
      chk("bp_hold_ready", 32'(in_ready), 0);
      chk("bp_hold_med", 32'(med_valid), 1);
    end
    med_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_arr_x6", arr_x, 6);
    chk("bp_arr_old6", arr_old, 2);
    send(32'd7, acc);
    chk("bp_arr_x7", arr_x, 7);
    chk("bp_arr_old7", arr_old, 3);

    // stop with a sample offered in RUN.
    stop     = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd99;
    #1;
    chk("stop_no_ready", 32'(in_ready), 0);
    tick();
    stop     = 1'b0;
    in_valid = 1'b0;
    chk("stop_ce", 32'(arr_ce), 0);
    chk("stop_clear", 32'(arr_clear), 1);
    chk("stop_busy", 32'(busy), 1);
    chk("stop_arr_x", arr_x, 7);
    tick();
    chk("stop_clear_done", 32'(arr_clear), 0);
    chk("stop_idle", 32'(busy), 0);

    // Reset mid-RUN after 7 samples.
    do_start(5'd5);
    tick();
    for (int k = 1; k <= 7; k++) send(32'(k + 40), acc);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("midrst");
    clr_cnt = 0;
    do_start(5'd5);
    for (int c = 0; c < 6; c++) begin
      if (arr_clear) clr_cnt++;
      tick();
    end
    chk("midrst_clear_pulses", 32'(clr_cnt), 1);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/median_window_ctrl.md
Name: median_window_ctrl

Overview:
- Sequencer for the FIFO-based systolic median filter array, which is built from a chain of medianFilterCell instances.
- Accepts a sample stream over a valid/ready handshake and keeps a W-deep history of samples.
- Each cycle it drives the array's broadcast sample X, the expiring sample R_old, the array clock-enable and the array clear.
- Emits a median-valid strobe and a median tap index once the window has filled.

Parameters:
- DATA_LENGTH, 32: sample width; equals the `DATA_LENGTH macro in macro.vh.
- WMAX, 16: maximum window size; equals the `WMAX macro.
- LOG_WMAX, 4: log2(WMAX), used for pointer widths; equals the `LOG_WMAX macro.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse; latches cfg_w and begins a run. Honoured only in IDLE.
- stop, in, 1: one-cycle pulse; ends the run and clears the array.
- cfg_w, in, LOG_WMAX+1: requested window size W.
- in_valid, in, 1: input sample valid.
- in_data, in, DATA_LENGTH: input sample.
- in_ready, out, 1: controller accepts a sample this cycle.
- arr_x, out, DATA_LENGTH: X broadcast to all cells (registered).
- arr_old, out, DATA_LENGTH: R_old broadcast to all cells (registered).
- arr_old_vld, out, 1: arr_old is a real expiring sample (0 during fill).
- arr_ce, out, 1: array registers update this cycle.
- arr_clear, out, 1: one-cycle array clear (drives the cells' reset).
- med_valid, out, 1: the array tap med_sel holds the current window median.
- med_ready, in, 1: downstream consumed the median.
- med_sel, out, LOG_WMAX: tap index (W-1)>>1.
- busy, out, 1: state is not IDLE.

Behaviour:
- Reset values: state=IDLE, all pointers and counters 0, arr_x=0, arr_old=0, every 1-bit output 0, med_sel=0. Reset takes priority over every other input, including mid-run; no history survives it.
- W latch: on start in IDLE, W_r = cfg_w, with cfg_w=0 clamped to 1 and cfg_w>WMAX clamped to WMAX. med_sel = (W_r-1)>>1 and is held until the next start.
- States:
  - IDLE: start -> CLEAR.
  - CLEAR: one cycle, arr_clear=1, pointers and fill_cnt zeroed -> FILL.
  - FILL: fill_cnt < W_r.
  - RUN: window full.
  - stop from FILL or RUN -> CLEAR_OUT; stop has priority over a same-cycle accept, and that sample is dropped.
  - CLEAR_OUT: one cycle, arr_clear=1 -> IDLE.
- Accept rule: accept = in_valid & in_ready, with in_ready = (FILL|RUN) & !stop & (!med_valid | med_ready).
- On accept, cycle n:
  - arr_x <= in_data and arr_ce <= 1 (visible in cycle n+1).
  - arr_ce is 0 in every cycle with no accept.
- History buffer:
  - WMAX entries; write pointer wp wraps at W_r-1 -> 0, not at WMAX.
  - On accept, the buffer reads entry wp, then writes in_data to wp (read-before-write, same cycle).
  - In RUN: arr_old <= read value, arr_old_vld <= 1. In FILL: arr_old_vld <= 0 and arr_old is don't-care.
- Fill counter: fill_cnt increments on accept in FILL. The accept that makes fill_cnt == W_r moves the state to RUN; that sample is still a fill insertion (arr_old_vld=0).
- Median latency:
  - Array registers update at the end of cycle n+1, so med_valid rises in cycle n+2 for the W_r-th accept and every later accept.
  - med_valid clears when med_ready=1 and no new median is due that cycle.
- Backpressure: while med_valid=1 and med_ready=0, in_ready=0 and arr_ce=0, so the array holds.
- W_r=1: FILL lasts one sample. Thereafter every accept has arr_old_vld=1 and arr_old = previous sample; med_sel=0.
- start in FILL or RUN is ignored; cfg_w changes outside IDLE are ignored.
- Simultaneous start and stop in IDLE: start wins (stop is meaningless in IDLE).

Decomposition:
- Shared constants stay in macro.vh (`DATA_LENGTH, `WMAX, `LOG_WMAX).
- Add to macro.vh a state-encoding block: IDLE=0, CLEAR=1, FILL=2, RUN=3, CLEAR_OUT=4 (3 bits).
- One sub-module: window_history_buf.
  - WMAX x DATA_LENGTH register array.
  - Pointer wrapping at W_r.
  - Synchronous read-before-write port.
- The controller FSM, counters and output registers stay in median_window_ctrl.

Test Plan:
- Reset mid-RUN (W=5, 7 samples in):
  - Expected: all outputs 0 and state IDLE the next cycle.
  - Then: a new start gives exactly one arr_clear pulse.
- W=5, stream 10,20,30,40,50,60, med_ready=1:
  - Expected: arr_old_vld=0 for the first 5 accepts; accept 6 gives arr_old=10.
  - Expected: med_valid first seen 2 cycles after accept 5; med_sel=2.
- W=3, 8 samples 1..8:
  - Expected: arr_old sequence 1,2,3,4,5 on accepts 4..8, confirming the wrap at 3, not WMAX.
- cfg_w=0, then a separate run with cfg_w=31, WMAX=16:
  - Expected: W_r=1 with med_sel=0; then W_r=16 with med_sel=7.
- W=4 in RUN, med_ready held 0 for 3 cycles with in_valid=1:
  - Expected: in_ready=0 and arr_ce=0 throughout, no sample lost.
  - After release: the accepted sample order is unchanged.
- stop asserted with in_valid=1 in RUN:
  - Expected: no accept, CLEAR_OUT lasts 1 cycle with arr_clear=1, busy=0 the following cycle.
